// File: rtl/sequence_sched_pkg.sv
// Shared types and the round-robin pick helper for the sequence scheduler.
package sequence_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MODE_W  = 2;
    localparam int DEF_LEN_W   = 8;

    // Helper works on a fixed maximum width; callers zero-extend and pass NUM_REQ-1 as mask.
    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_IDX_W-1:0] ptr,
                                         input logic [MAX_IDX_W-1:0] mask);
        rr_pick_t             r;
        logic [MAX_IDX_W-1:0] off;
        logic [MAX_IDX_W-1:0] j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            off = MAX_IDX_W'(k);
            j   = (ptr + off) & mask;
            if (!r.found && (off <= mask) && req[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter
    import sequence_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] grant
);

    rr_pick_t pick;
    logic     unused_idx_hi;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr), MAX_IDX_W'(NUM_REQ - 1));
        found = pick.found;
        grant = pick.idx[$clog2(NUM_REQ)-1:0];
    end

    assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/sequence_scheduler.sv
// Round-robin scheduler sharing one sequence generator among NUM_REQ burst requesters.
module sequence_scheduler
    import sequence_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MODE_W  = DEF_MODE_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*MODE_W-1:0]    req_mode,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic                         gen_start,
    output logic [MODE_W-1:0]            gen_mode,
    output logic                         gen_enable,
    input  logic [DATA_W-1:0]            gen_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic                         out_last,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Valid/ready: a beat transfers on a rising edge where out_valid and out_ready are both
    // high; out_valid never depends on out_ready, and a stalled beat stays unchanged until
    // taken. req_ready is a one-cycle grant pulse; the request is consumed at that edge.

    sched_state_t     state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, id_q, grant;
    logic [MODE_W-1:0] mode_q;
    logic [LEN_W-1:0] len_q, count, grant_len;
    logic             found, accept, handshake, last_beat;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .grant (grant)
    );

    assign grant_len = req_len[int'(grant)*LEN_W +: LEN_W];
    assign accept    = (state == IDLE) && found;
    assign handshake = (state == RUN) && out_ready;
    // count only reaches len on the final handshake, so it cannot wrap even at max length.
    assign last_beat = (count == len_q - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            mode_q <= '0;
            len_q  <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                id_q   <= grant;
                mode_q <= req_mode[int'(grant)*MODE_W +: MODE_W];
                len_q  <= grant_len;
            end
            if (state == LOAD)   count <= '0;
            else if (handshake)  count <= count + 1'b1;
            if (state == DONE)   rr_ptr <= id_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = (grant_len != '0) ? LOAD : DONE;
            LOAD:    state_nxt = RUN;
            RUN:     if (out_ready && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        gen_start  = 1'b0;
        gen_enable = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_id     = '0;
        out_last   = 1'b0;
        case (state)
            IDLE: if (found) req_ready[grant] = 1'b1;
            LOAD: gen_start = 1'b1;
            RUN: begin
                out_valid  = 1'b1;
                out_data   = gen_data;
                out_id     = id_q;
                out_last   = last_beat;
                gen_enable = out_ready;
            end
            default: ;
        endcase
    end

    assign gen_mode  = mode_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sequence_scheduler.sv
// Bench for sequence_scheduler: generator stand-in, burst-level reference model, directed and random bursts.
module tb_sequence_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int MODE_W  = 2;
    localparam int LEN_W   = 8;
    localparam int IDX_W   = 2;
    localparam int W       = 1 + IDX_W + DATA_W;
    localparam int NEVER   = 32'h7fff_ffff;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*MODE_W-1:0]  req_mode = '0;
    logic [NUM_REQ*LEN_W-1:0]   req_len = '0;
    logic                       gen_start;
    logic [MODE_W-1:0]          gen_mode;
    logic                       gen_enable;
    logic [DATA_W-1:0]          gen_data = '0;
    logic                       out_valid;
    logic                       out_ready = 1'b1;
    logic [DATA_W-1:0]          out_data;
    logic [IDX_W-1:0]           out_id;
    logic                       out_last;
    logic                       busy;
    logic [1:0]                 state_dbg;

    sequence_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MODE_W(MODE_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_len(req_len), .gen_start(gen_start), .gen_mode(gen_mode),
        .gen_enable(gen_enable), .gen_data(gen_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_last(out_last), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- generator stand-in ----------------
    // Mode m starts at 17*(m+1) and steps by 2m+1, so beat k of a burst is seed + k*stride.
    function automatic logic [7:0] beat_val(input int m, input int k);
        return 8'((17 * (m + 1)) + k * (2 * m + 1));
    endfunction

    always @(posedge clk) begin
        if (gen_start)       gen_data <= 8'(17 * (int'(gen_mode) + 1));
        else if (gen_enable) gen_data <= gen_data + 8'(2 * int'(gen_mode) + 1);
    end

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0]       exp_q[$];
    int                 grant_log[$];
    logic [NUM_REQ-1:0] ack_mask = '0;
    logic [MODE_W-1:0]  model_mode = '0;
    int model_ptr = 0, free_cyc = 0, start_cyc = -1, beat_from = NEVER, beats_left = 0;
    int dut_hs = 0, en_total = 0, start_total = 0, last_total = 0, grant_cyc = 0, last_cyc = 0;
    bit rand_ready = 1'b0;

    always @(negedge clk) begin
        int   pick;
        int   l;
        logic exp_ov;
        if (reset_n) begin
            pick = -1;
            if (cyc >= free_cyc)
                for (int k = 0; k < NUM_REQ; k++)
                    if (pick < 0 && req_valid[(model_ptr + k) % NUM_REQ]) pick = (model_ptr + k) % NUM_REQ;
            check("busy", busy, cyc < free_cyc);
            check("req_ready", req_ready, (pick < 0) ? 0 : (1 << pick));
            check("gen_mode", gen_mode, model_mode);
            check("gen_start", gen_start, cyc == start_cyc);
            exp_ov = (beats_left > 0) && (cyc >= beat_from);
            check("out_valid", out_valid, exp_ov);
            check("gen_enable", gen_enable, exp_ov && out_ready);
            if (exp_ov && exp_q.size() > 0) begin
                check("beat", {out_last, out_id, out_data}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_left--;
                    if (beats_left == 0) free_cyc = cyc + 2;
                end
            end
            if (pick >= 0) begin
                l          = int'(req_len[pick*LEN_W +: LEN_W]);
                model_mode = req_mode[pick*MODE_W +: MODE_W];
                grant_log.push_back(pick);
                grant_cyc      = cyc;
                model_ptr      = (pick + 1) % NUM_REQ;
                ack_mask[pick] = 1'b1;
                if (l == 0) begin
                    free_cyc = cyc + 2;
                end else begin
                    free_cyc   = NEVER;
                    start_cyc  = cyc + 1;
                    beat_from  = cyc + 2;
                    beats_left = l;
                    for (int k = 0; k < l; k++)
                        exp_q.push_back({k == l - 1, IDX_W'(pick), beat_val(int'(model_mode), k)});
                end
            end
            if (out_valid && out_ready) begin
                dut_hs++;
                if (out_last) begin last_total++; last_cyc = cyc; end
            end
            if (gen_enable) en_total++;
            if (gen_start)  start_total++;
        end
    end

    // ---------------- driver tasks ----------------
    always @(posedge clk) begin
        #1;
        req_valid = req_valid & ~ack_mask;
        ack_mask  = '0;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic set_req(input int i, input int m, input int l);
        req_mode[i*MODE_W +: MODE_W] = MODE_W'(m);
        req_len[i*LEN_W +: LEN_W]    = LEN_W'(l);
        req_valid[i]                 = 1'b1;
    endtask

    task automatic post_req(input int i, input int m, input int l);
        int t = 0;
        @(posedge clk); #2;
        while (req_valid[i] && t < 3000) begin @(posedge clk); #2; t++; end
        check("post_timeout", req_valid[i], 0);
        set_req(i, m, l);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(posedge clk); #2; t++; end
        while ((req_valid != '0 || busy || exp_q.size() != 0) && t < 5000);
        check("idle_timeout", t >= 5000, 0);
    endtask

    task automatic wait_hs(input int target);
        int t = 0;
        while (dut_hs < target && t < 1000) begin @(negedge clk); #1; t++; end
        check("hs_timeout", dut_hs >= target, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("reset_outputs", {req_ready, gen_start, gen_mode, gen_enable, out_valid,
                                out_data, out_id, out_last, busy}, 0);
        req_valid = '0; req_mode = '0; req_len = '0; ack_mask = '0;
        exp_q.delete(); grant_log.delete();
        model_ptr = 0; free_cyc = 0; start_cyc = -1; beat_from = NEVER; beats_left = 0;
        model_mode = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int hs0, en0, st0, lt0, n0;
    logic [NUM_REQ-1:0] mask;

    initial begin
        do_reset();

        // single request, req 2, mode 1, len 3
        post_req(2, 1, 3);
        wait_idle();
        check("t1_grant", grant_log[0], 2);
        check("t1_last_latency", last_cyc - grant_cyc, 4);

        // all four at once, len 1; requester 0 re-requests after its grant
        do_reset();
        @(posedge clk); #2;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom_range(0, 3), 1);
        post_req(0, 3, 1);
        wait_idle();
        check("t2_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) check("t2_order", grant_log[i], i % NUM_REQ);

        // backpressure on beat 2 of a len 4 burst
        hs0 = dut_hs; en0 = en_total;
        post_req(1, 2, 4);
        wait_hs(hs0 + 2);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        check("t3_handshakes", dut_hs - hs0, 4);
        check("t3_enables", en_total - en0, 4);

        // zero length rotates the pointer without a burst
        hs0 = dut_hs; st0 = start_total;
        post_req(1, 3, 0);
        wait_idle();
        check("t4_no_start", start_total - st0, 0);
        check("t4_no_beats", dut_hs - hs0, 0);
        n0 = grant_log.size();
        @(posedge clk); #2;
        set_req(1, 0, 1);
        set_req(2, 1, 1);
        wait_idle();
        check("t4_next_grant", grant_log[n0], 2);

        // reset during beat 2 of a len 5 burst, then a fresh full burst
        hs0 = dut_hs;
        post_req(0, 3, 5);
        wait_hs(hs0 + 2);
        do_reset();
        hs0 = dut_hs; st0 = start_total;
        post_req(3, 2, 5);
        wait_idle();
        check("t5_grant", grant_log[0], 3);
        check("t5_start", start_total - st0, 1);
        check("t5_beats", dut_hs - hs0, 5);

        // maximum length burst
        hs0 = dut_hs; lt0 = last_total;
        post_req($urandom_range(0, 3), $urandom_range(0, 3), 255);
        wait_idle();
        check("t6_beats", dut_hs - hs0, 255);
        check("t6_last_once", last_total - lt0, 1);

        // random bursts with random backpressure
        rand_ready = 1'b1;
        repeat (30) begin
            mask = NUM_REQ'($urandom_range(1, 15));
            @(posedge clk); #2;
            for (int i = 0; i < NUM_REQ; i++)
                if (mask[i]) set_req(i, $urandom_range(0, 3), $urandom_range(0, 6));
            wait_idle();
        end
        rand_ready = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_scheduler.md
Name: sequence_scheduler

Overview:
- Round-robin scheduler that shares one sequence_generator among NUM_REQ requesters.
- Each requester submits a burst request (mode, length).
- The scheduler grants one request at a time, restarts the generator in the requested mode, steps it once per accepted output beat, and tags each beat with the requester id.
- Sits between the requester agents and the single sequence_generator instance.

Parameters:
- NUM_REQ, 4: number of requesters, power of two, minimum 2.
- DATA_W, 8: generator data width.
- MODE_W, 2: generator mode-select width.
- LEN_W, 8: burst length width; a burst is 0..2^LEN_W-1 beats.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request pending.
- req_ready  output  NUM_REQ  one-hot pulse; request accepted this cycle.
- req_mode  input  NUM_REQ*MODE_W  packed mode per requester; slice i belongs to requester i.
- req_len  input  NUM_REQ*LEN_W  packed burst length per requester.
- gen_start  output  1  one-cycle pulse; generator reloads its seed for gen_mode.
- gen_mode  output  MODE_W  mode of the active burst, held for the whole burst.
- gen_enable  output  1  advance generator one step at the next edge.
- gen_data  input  DATA_W  current generator value; valid from the cycle after gen_start.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DATA_W  beat data, equal to gen_data.
- out_id  output  $clog2(NUM_REQ)  owner of the beat.
- out_last  output  1  final beat of the burst.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, count=0, latched mode/len/id=0. All outputs 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally in this cycle only.
  - Latch mode, len and id at the clock edge.
  - Next state: LOAD if len!=0, else DONE.
- LOAD: gen_start=1, gen_mode=latched mode, count cleared. Next state: RUN.
- RUN:
  - out_valid=1, out_data=gen_data, out_id=latched id.
  - out_last=1 when count==len-1.
  - gen_enable=out_valid&out_ready. On that handshake, count increments.
  - On the handshake with out_last=1, go to DONE.
  - out_ready low: hold every output stable; gen_enable=0.
- DONE: rr_ptr=latched id+1, mod NUM_REQ. Next state: IDLE.
- Latency:
  - Request accepted in cycle T: gen_start in T+1, first out_valid in T+2.
  - Minimum gap between the last beat of one burst and the next grant: 2 cycles (DONE, IDLE).
- gen_mode holds its value from LOAD through DONE and is unchanged in IDLE.
- Zero-length request is accepted, produces no beats and no gen_start, but still rotates rr_ptr.
- req_valid that rises or falls while busy is ignored until IDLE. Requesters must hold req_valid, mode and len stable until req_ready.
- Maximum length 2^LEN_W-1: count never wraps; out_last fires when count==len-1.
- Simultaneous requests: exactly one req_ready bit per grant; the others wait with no loss.
- Reset mid-burst: outputs drop immediately; the partial burst is abandoned and not resumed; rr_ptr returns to 0.

Decomposition:
- Package sequence_sched_pkg:
  - state enum sched_state_t {IDLE, LOAD, RUN, DONE}.
  - Default width localparams.
  - Function rr_pick(req, ptr) returning grant index and found flag.
- Sub-module rr_arbiter (parameterised by NUM_REQ): combinational round-robin pick from req vector and ptr.
- Scheduler FSM, counter and output mux stay in sequence_scheduler.

Test Plan:
1. Single request, req 2, mode=1, len=3, out_ready=1:
   - req_ready=0100 at T, gen_start at T+1.
   - Beats at T+2..T+4, out_id=2, out_last at T+4.
   - busy falls at T+6.
2. All four requesters valid, each len=1:
   - Grant order 0,1,2,3, then 0 again when requester 0 re-requests.
   - No grant repeats while others are pending.
3. Backpressure, len=4:
   - out_ready low for 3 cycles at beat 2.
   - out_data, out_id and out_last stay stable; gen_enable=0 throughout.
   - Exactly 4 handshakes and 4 gen_enable pulses.
4. Zero length:
   - req 1, len=0 -> req_ready pulse, no gen_start, no out_valid.
   - rr_ptr becomes 2; next simultaneous req 1 and req 2 grants 2.
5. Reset asserted during beat 2 of a len=5 burst:
   - All outputs 0 in the same cycle.
   - After release, a new request to req 3 starts with gen_start and gets a full 5 beats.
6. len=255 burst: out_last only on beat 255; count does not overflow.
